// File: rtl/game_timer_if.sv
// Control/status bundle between the game logic, display driver and the countdown clock.
interface game_timer_if;
  logic        tick;
  logic        start;
  logic        pause;
  logic        load;
  logic [15:0] load_bcd;
  logic [15:0] digits;
  logic        running;
  logic        warning;
  logic        expired;
  logic        done;
  logic        load_err;

  modport master (
    output tick, start, pause, load, load_bcd,
    input  digits, running, warning, expired, done, load_err
  );

  modport slave (
    input  tick, start, pause, load, load_bcd,
    output digits, running, warning, expired, done, load_err
  );
endinterface

// File: rtl/game_timer.sv
// Countdown MM:SS game clock in BCD, driven by an external tick enable.
// Flags low time while running and pulses once when 00:00 is reached.
module game_timer #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned WARN_SEC      = 10
) (
  input logic        clk,
  input logic        reset,
  game_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  localparam logic [15:0] PrescMax = 16'(TICKS_PER_SEC - 1);
  localparam logic [6:0]  WarnSec  = 7'(WARN_SEC);

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [15:0] presc_q, presc_d;
  logic        expired_q, expired_d;
  logic        load_err_q, load_err_d;
  logic        load_valid;
  logic [15:0] digits_dec;
  logic [6:0]  sec_val;

  // One-second BCD decrement; 00:00 never reaches here in RUN.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      digits_q   <= 16'h0000;
      presc_q    <= 16'h0000;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      presc_q    <= presc_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  assign load_valid = (bus.load_bcd[15:12] <= 4'd9) && (bus.load_bcd[11:8] <= 4'd9) &&
                      (bus.load_bcd[7:4] <= 4'd5) && (bus.load_bcd[3:0] <= 4'd9);
  assign digits_dec = bcd_dec(digits_q);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    presc_d    = presc_q;
    expired_d  = 1'b0;
    load_err_d = 1'b0;
    if (bus.load && state_q != StRun) begin
      if (load_valid) begin
        digits_d = bus.load_bcd;
        presc_d  = 16'h0000;
        state_d  = StIdle;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (state_q == StRun) begin
      if (bus.pause) begin
        state_d = StPause;
      end
      // A tick coincident with pause still counts, and expiry overrides the pause.
      if (bus.tick) begin
        if (presc_q == PrescMax) begin
          presc_d  = 16'h0000;
          digits_d = digits_dec;
          if (digits_dec == 16'h0000) begin
            state_d   = StExpired;
            expired_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
    end else if (bus.start && (state_q == StIdle || state_q == StPause) &&
                 digits_q != 16'h0000) begin
      state_d = StRun;
    end
  end

  always_comb begin
    sec_val      = 7'({3'b000, digits_q[7:4]} * 7'd10) + {3'b000, digits_q[3:0]};
    bus.digits   = digits_q;
    bus.running  = (state_q == StRun);
    bus.done     = (state_q == StExpired);
    bus.warning  = (state_q == StRun) && (digits_q[15:8] == 8'h00) && (sec_val <= WarnSec);
    bus.expired  = expired_q;
    bus.load_err = load_err_q;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Countdown game clock for the maze game, fed directly by the tick generator: it consumes the one-clock-wide `tick` enable and counts whole seconds down from a loaded MM:SS value. It presents four BCD digits to the display driver and flags the game logic when time runs low and when it expires. Start, pause and load come from debounced player or game-FSM pulses.

## Interface
- `TICKS_PER_SEC`, default 100. Number of `tick` pulses per second. Range 1–65535.
- `WARN_SEC`, default 10. Warning threshold in seconds. Range 0–59.
- `clk`  in  1  system clock; every register updates on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `tick`  in  1  one-cycle enable from the tick generator
- `start`  in  1  single-cycle pulse; start or resume the countdown
- `pause`  in  1  single-cycle pulse; freeze the countdown
- `load`  in  1  single-cycle pulse; capture `load_bcd`
- `load_bcd`  in  16  {min tens, min ones, sec tens, sec ones}, BCD
- `digits`  out  16  current time, same packing as `load_bcd`
- `running`  out  1  high while in RUN
- `warning`  out  1  high in RUN when remaining time ≤ `WARN_SEC` seconds
- `expired`  out  1  one-cycle pulse when the count reaches 00:00
- `done`  out  1  level, high while in EXPIRED
- `load_err`  out  1  one-cycle pulse when a load is rejected

## Operation
- States:
  - IDLE: loaded and not counting.
  - RUN: counting.
  - PAUSE: frozen.
  - EXPIRED: reached zero.
- Reset: state = IDLE, `digits` = 0x0000, prescaler = 0, all outputs 0.
- Load:
  - Accepted in IDLE, PAUSE and EXPIRED; ignored in RUN, with no `load_err`.
  - A load is valid when every nibble is ≤ 9 and the sec-tens nibble is ≤ 5.
  - Valid load: `digits` ← `load_bcd`, prescaler ← 0, state → IDLE.
  - Invalid load: `load_err` pulses; `digits`, prescaler and state are unchanged.
- `start`:
  - In IDLE or PAUSE with `digits` ≠ 0 → RUN.
  - With `digits` = 0, in EXPIRED, or in RUN → no effect.
  - Resuming from PAUSE keeps the prescaler value; a partial second is not lost.
- `pause`: in RUN → PAUSE. Ignored in all other states.
- Same-cycle priority: `load` > `pause` > `start`. A `tick` in the same cycle as an accepted `pause` is still counted.
- Counting in RUN, on each `tick`:
  - If prescaler = `TICKS_PER_SEC` − 1: prescaler ← 0 and `digits` decrements by one second.
  - Otherwise: prescaler + 1.
- Decrement uses a BCD borrow chain:
  - sec ones wraps 0 → 9 and borrows from sec tens.
  - sec tens wraps 0 → 5 and borrows from min ones.
  - min ones wraps 0 → 9 and borrows from min tens.
- Expiry: a decrement that yields 0x0000 moves the state to EXPIRED and pulses `expired` once. Further ticks have no effect.
- Maximum value is 99:59. Because loads are validated, 00:00 is the only underflow case.
- `warning` = RUN and minutes = 0 and (sec tens × 10 + sec ones) ≤ `WARN_SEC`.
- `running` = (state == RUN). `done` = (state == EXPIRED).

## Timing
- All state, `digits`, `expired` and `load_err` are registered.
- `running`, `warning` and `done` decode registered state only; they have no combinational path from any input.
- `digits` updates on the clock edge that samples the completing `tick`, so it is visible 1 cycle after that tick.
- `expired` is high in the same cycle that `digits` first reads 0x0000 and `done` first reads 1.
- `load` and `load_err` take effect 1 cycle after the pulse.
- `start` and `pause`: `running` changes 1 cycle after the pulse. A `tick` coincident with `start` is not counted, because the state is not yet RUN.
- Back-to-back `tick`s on consecutive cycles are fully supported.
- `reset` asserted at any time, including mid-second in RUN, clears everything immediately. No output glitches after deassertion.

## Test plan
- Reset and count: reset, then `TICKS_PER_SEC`=4, load 0x0003, start, `tick` every cycle → `digits` 0002/0001/0000 after ticks 4/8/12; `expired` pulses once with `done` = 1; ticks 13–20 change nothing.
- Borrow chain: load 0x1000, run 1 s → 0x0959; load 0x0100, run 1 s → 0x0059.
- Invalid loads: 0x0A00 and 0x0060 each produce one `load_err` pulse and leave `digits` unchanged. A `load` issued in RUN produces no change and no error.
- Pause preserves the partial second: with `TICKS_PER_SEC`=4, 2 ticks, pause, 5 ticks, start, 2 ticks → exactly one decrement, after the resume.
- `warning`: `WARN_SEC`=10, load 0x0012, run → `warning` rises when `digits` = 0x0010 and is low in PAUSE.
- Reset mid-run: assert `reset` at 0x0105 with the prescaler nonzero → 0x0000, IDLE, all outputs 0. Subsequent `start` with no load has no effect.
